// File: rtl/spi_read.sv
// SPI mode-0 read slave: an 8-bit address phase selects this instance, then the
// captured inport word is shifted out on miso MSB first, with clr pulsed on completion.
module spi_read #(
  parameter int unsigned Nbit      = 32,
  parameter logic [7:0]  param_adr = 8'h01
) (
  input  logic            clk,
  input  logic            srstb,
  input  logic            sclk,
  input  logic            mosi,
  output logic            miso,
  input  logic            cs,
  output logic            clr,
  input  logic [Nbit-1:0] inport
);

  localparam int unsigned CntW = 6;
  localparam logic [CntW-1:0] AddrLast = CntW'(7);
  localparam logic [CntW-1:0] DataLast = CntW'(Nbit - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  logic            sclk_s1, sclk_s2, sclk_p;
  logic            mosi_s1, mosi_s2;
  logic            cs_s1, cs_s2, cs_p;
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d;
  logic [Nbit-1:0] sr_q, sr_d;
  logic            miso_q, miso_d;
  logic            clr_q, clr_d;

  logic            sclk_rise, sclk_fall, cs_fall;
  logic [7:0]      addr_next;

  // Synchronizers plus a delayed copy for edge detection. cs_p resets low so a
  // cs held low across reset never looks like a falling edge.
  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_p  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      cs_s1   <= 1'b0;
      cs_s2   <= 1'b0;
      cs_p    <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_p  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      cs_s1   <= cs;
      cs_s2   <= cs_s1;
      cs_p    <= cs_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_p;
  assign sclk_fall = ~sclk_s2 & sclk_p;
  assign cs_fall   = ~cs_s2 & cs_p;
  assign addr_next = {addr_q[6:0], mosi_s2};

  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      sr_q    <= '0;
      miso_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      miso_q  <= miso_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    miso_d  = miso_q;
    clr_d   = 1'b0;

    if (cs_s2) begin
      state_d = StIdle;
      cnt_d   = '0;
      miso_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          miso_d = 1'b0;
          cnt_d  = '0;
          if (cs_fall) begin
            state_d = StAddr;
          end
        end
        StAddr: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            addr_d = addr_next;
            if (cnt_q == AddrLast) begin
              cnt_d = '0;
              if (addr_next == param_adr) begin
                sr_d    = inport;
                state_d = StData;
              end else begin
                state_d = StDone;
              end
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StData: begin
          // The first fall after the capture presents bit Nbit-1; later falls
          // present the following bits as the register shifts left.
          if (sclk_fall) begin
            miso_d = sr_q[Nbit-1];
            sr_d   = sr_q << 1;
          end
          if (sclk_rise) begin
            if (cnt_q == DataLast) begin
              clr_d   = 1'b1;
              miso_d  = 1'b0;
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = StIdle;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  assign miso = miso_q;
  assign clr  = clr_q;

endmodule

// File: tb/tb_spi_read.sv
// Bench for spi_read: table of framed reads, random frames against a word-level
// model, and hand-written inport-change and mid-frame reset sequences.
module tb_spi_read;

  logic        clk = 1'b0;
  logic        srstb;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        cs;
  logic        clr;
  logic [31:0] inport;

  int n_checks = 0;
  int n_err    = 0;
  int clr_cnt  = 0;

  spi_read #(.Nbit(32), .param_adr(8'h01)) dut (
    .clk    (clk),
    .srstb  (srstb),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .cs     (cs),
    .clr    (clr),
    .inport (inport)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (clr === 1'b1) clr_cnt++;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          ndata;
    logic [31:0] exp_word;
    int          exp_clr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word the master should assemble: only a matching address yields data, and
  // bits clocked after a reset come back as zero.
  function automatic logic [31:0] model(input logic [7:0] addr, input logic [31:0] val,
                                        input int ndata, input int rst_at);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < ndata; i++) begin
      w = {w[30:0], (addr == 8'h01 && (rst_at < 0 || i < rst_at)) ? val[31-i] : 1'b0};
    end
    return w;
  endfunction

  // One sclk period, mode 0: master samples miso just before the rising edge.
  task automatic sclk_bit(input logic b, output logic s);
    mosi = b;
    repeat (5) @(posedge clk);
    #1 s = miso;
    sclk = 1'b1;
    repeat (5) @(posedge clk);
    #1 sclk = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] addr, input logic [31:0] val, input int ndata,
                           input int chg_at, input logic [31:0] chg_val, input int rst_at,
                           output logic [31:0] word, output int clr_n, output int clr_early,
                           output logic addr_bad);
    logic s;
    int   c0;
    word      = '0;
    addr_bad  = 1'b0;
    clr_early = 0;
    inport    = val;
    cs        = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      sclk_bit(addr[7-i], s);
      if (s !== 1'b0) addr_bad = 1'b1;
    end
    c0 = clr_cnt;
    for (int i = 0; i < ndata; i++) begin
      if (i == chg_at) inport = chg_val;
      if (i == rst_at) begin
        srstb = 1'b0;
        #1;
        check("rst_miso_immediate", {31'd0, miso}, 32'd0);
        check("rst_clr_immediate", {31'd0, clr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 srstb = 1'b1;
      end
      if (i == ndata - 1) clr_early = clr_cnt - c0;
      sclk_bit(1'($urandom), s);
      word = {word[30:0], s};
    end
    repeat (6) @(posedge clk);
    clr_n = clr_cnt - c0;
    cs = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic frame_checks(input string tag, input logic [31:0] word, input logic [31:0] exp_w,
                              input int clr_n, input int exp_clr, input int clr_early,
                              input logic addr_bad);
    check({tag, "_word"}, word, exp_w);
    check({tag, "_clr_count"}, 32'(clr_n), 32'(exp_clr));
    check({tag, "_clr_not_early"}, 32'(clr_early), 32'd0);
    check({tag, "_addr_phase_miso"}, {31'd0, addr_bad}, 32'd0);
    check({tag, "_idle_miso"}, {31'd0, miso}, 32'd0);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] exp_w;
    logic [7:0]  a;
    logic [31:0] d;
    int          clr_n, clr_early, exp_clr;
    logic        addr_bad;

    vecs[0] = '{8'h01, 32'hDEEDBEEF, 32, 32'hDEEDBEEF, 1};
    vecs[1] = '{8'h01, 32'h00000044, 32, 32'h00000044, 1};
    vecs[2] = '{8'h03, 32'h00000044, 32, 32'h00000000, 0};
    vecs[3] = '{8'h01, 32'hA5A5F00F, 10, 32'h00000296, 0};
    vecs[4] = '{8'h01, 32'h12345678, 32, 32'h12345678, 1};

    srstb  = 1'b0;
    sclk   = 1'b0;
    mosi   = 1'b0;
    cs     = 1'b1;
    inport = '0;
    #1;
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_clr", {31'd0, clr}, 32'd0);
    repeat (3) @(posedge clk);
    #1 srstb = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    foreach (vecs[k]) begin
      run_frame(vecs[k].addr, vecs[k].data, vecs[k].ndata, -1, '0, -1,
                word, clr_n, clr_early, addr_bad);
      frame_checks($sformatf("vec%0d", k), word, vecs[k].exp_word, clr_n, vecs[k].exp_clr,
                   clr_early, addr_bad);
    end

    for (int r = 0; r < 6; r++) begin
      a = ($urandom % 2 == 0) ? 8'h01 : 8'($urandom);
      d = $urandom;
      exp_w   = model(a, d, 32, -1);
      exp_clr = (a == 8'h01) ? 1 : 0;
      run_frame(a, d, 32, -1, '0, -1, word, clr_n, clr_early, addr_bad);
      frame_checks($sformatf("rand%0d", r), word, exp_w, clr_n, exp_clr, clr_early, addr_bad);
    end

    // inport changes during DATA; the frame keeps the captured word.
    run_frame(8'h01, 32'h00000044, 32, 5, 32'h00000045, -1, word, clr_n, clr_early, addr_bad);
    frame_checks("chg_frame", word, 32'h00000044, clr_n, 1, clr_early, addr_bad);
    run_frame(8'h01, 32'h00000045, 32, -1, '0, -1, word, clr_n, clr_early, addr_bad);
    frame_checks("chg_next", word, 32'h00000045, clr_n, 1, clr_early, addr_bad);

    // Reset mid-DATA with cs held low: output stays quiet for the rest of the frame.
    d = 32'hCAFEF00D;
    run_frame(8'h01, d, 32, -1, '0, 12, word, clr_n, clr_early, addr_bad);
    exp_w = model(8'h01, d, 32, 12);
    check("rst_frame_word", word, exp_w);
    check("rst_frame_clr", 32'(clr_n), 32'd0);
    run_frame(8'h01, 32'h0BADBEEF, 32, -1, '0, -1, word, clr_n, clr_early, addr_bad);
    frame_checks("rst_next", word, 32'h0BADBEEF, clr_n, 1, clr_early, addr_bad);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
